jtag_mem_bridge: RTL and testbench

Clock-domain bridge between the virtual-JTAG register block (tck domain) and a simple dual-port RAM in the system clock domain. It synchronises the JTAG write strobe, performs exactly one RAM write per JTAG write transaction, drives the RAM read address from the JTAG read-address register, and returns registered read data to the JTAG read-data register. It sits directly downstream of the JTAG top level and consumes its wdata/raddr/waddr/flags/wram_enable outputs, and feeds its rdata input.

---
 rtl/jtag_mem_bridge_if.sv | 30 +++
 rtl/jtag_mem_bridge.sv | 123 ++++++++++++
 tb/tb_jtag_mem_bridge.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_mem_bridge_if.sv
// Signal bundle between the JTAG register block, jtag_mem_bridge and the system-clock RAM.
// The master side is the bridge; the slave side is the JTAG block plus the RAM.
interface jtag_mem_bridge_if #(
    parameter int DW = 32,
    parameter int AW = 10
);
    logic          jtag_wram_enable;
    logic [DW-1:0] jtag_wdata;
    logic [DW-1:0] jtag_waddr;
    logic [DW-1:0] jtag_raddr;
    logic [DW-1:0] jtag_flags;
    logic [DW-1:0] jtag_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;
    logic [15:0]   wr_count;
    logic          busy;

    modport master (
        input  jtag_wram_enable, jtag_wdata, jtag_waddr, jtag_raddr, jtag_flags, mem_rdata,
        output jtag_rdata, mem_we, mem_waddr, mem_wdata, mem_raddr, wr_count, busy
    );

    modport slave (
        output jtag_wram_enable, jtag_wdata, jtag_waddr, jtag_raddr, jtag_flags, mem_rdata,
        input  jtag_rdata, mem_we, mem_waddr, mem_wdata, mem_raddr, wr_count, busy
    );
endinterface

// File: rtl/jtag_mem_bridge.sv
// tck-to-clk bridge: synchronises the JTAG write strobe, issues one RAM write per strobe and
// relays the read path. Define JTAG_MEM_AUTOINC_EN to enable the auto-incrementing write pointer.
module jtag_mem_bridge #(
    parameter int DW = 32,
    parameter int AW = 10
) (
    input  logic               clk,
    input  logic               reset,
    jtag_mem_bridge_if.master  bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, WRITE, WAIT_LOW} state_e;

    state_e        state_q, state_d;
    logic          s0_q, s1_q;
    logic          capture;
    logic          write_now;
    logic [AW-1:0] jtag_waddr_lo;
    logic [AW-1:0] waddr_d, waddr_q;
    logic [DW-1:0] wdata_q;
    logic [15:0]   wr_count_q;
    logic [AW-1:0] raddr_p0_q, raddr_p1_q, mem_raddr_q;
    logic [DW-1:0] rdata_q;
    logic          unused_bits;

    assign jtag_waddr_lo = bus.jtag_waddr[AW-1:0];
    assign unused_bits   = ^{bus.jtag_flags, bus.jtag_waddr, bus.jtag_raddr};

    // Strobe synchroniser; reset high so a strobe held across reset is not taken as a new edge
    always_ff @(posedge clk) begin
        if (reset) begin
            s0_q <= 1'b1;
            s1_q <= 1'b1;
        end else begin
            s0_q <= bus.jtag_wram_enable;
            s1_q <= s0_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= WAIT_LOW;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        write_now = 1'b0;
        case (state_q)
            IDLE:     if (s1_q) state_d = SETTLE;
            SETTLE: begin
                capture = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                write_now = !reset;
                state_d   = WAIT_LOW;
            end
            WAIT_LOW: if (!s1_q) state_d = IDLE;
            default:  state_d = WAIT_LOW;
        endcase
    end

`ifdef JTAG_MEM_AUTOINC_EN
    logic [AW-1:0] wptr_q, wlast_q;
    logic          reuse_ptr;

    // Re-sending the same base address with auto-increment continues from the pointer
    assign reuse_ptr = bus.jtag_flags[0] && (jtag_waddr_lo == wlast_q);
    assign waddr_d   = reuse_ptr ? wptr_q : jtag_waddr_lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            wlast_q <= '0;
        end else if (capture) begin
            wptr_q  <= waddr_d;
            wlast_q <= jtag_waddr_lo;
        end else if (write_now) begin
            wptr_q  <= wptr_q + {{(AW-1){1'b0}}, 1'b1};
        end
    end
`else
    assign waddr_d = jtag_waddr_lo;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            waddr_q <= '0;
            wdata_q <= '0;
        end else if (capture) begin
            waddr_q <= waddr_d;
            wdata_q <= bus.jtag_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)          wr_count_q <= '0;
        else if (write_now) wr_count_q <= wr_count_q + 16'd1;
    end

    // Read path: two resync stages, registered RAM address, registered read data
    always_ff @(posedge clk) begin
        if (reset) begin
            raddr_p0_q  <= '0;
            raddr_p1_q  <= '0;
            mem_raddr_q <= '0;
            rdata_q     <= '0;
        end else begin
            raddr_p0_q  <= bus.jtag_raddr[AW-1:0];
            raddr_p1_q  <= raddr_p0_q;
            mem_raddr_q <= raddr_p1_q;
            rdata_q     <= bus.mem_rdata;
        end
    end

    assign bus.mem_we     = write_now;
    assign bus.mem_waddr  = waddr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_raddr  = mem_raddr_q;
    assign bus.jtag_rdata = rdata_q;
    assign bus.wr_count   = wr_count_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_jtag_mem_bridge.sv
// Self-checking bench for jtag_mem_bridge: vector table, reset/strobe corner sequences and
// randomized writes/reads against a transaction-level memory model.
module tb_jtag_mem_bridge;
    localparam int DW = 32;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    jtag_mem_bridge_if #(.DW(DW), .AW(AW)) bus ();

    jtag_mem_bridge #(.DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // RAM with one-cycle registered read
    logic [DW-1:0] ram [1024];
    always @(posedge clk) begin
        bus.mem_rdata <= ram[bus.mem_raddr];
        if (bus.mem_we === 1'b1) ram[bus.mem_waddr] <= bus.mem_wdata;
    end

    int we_total = 0;
    always @(posedge clk) if (bus.mem_we === 1'b1) we_total++;

    // Reference model: contents the RAM should hold and number of writes since reset
    logic [DW-1:0] ref_mem [1024];
    logic [15:0]   exp_count;
    logic [9:0]    written_q [$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int hi,
                            output int first, output int n,
                            output logic [9:0] got_a, output logic [31:0] got_d);
        bus.jtag_waddr = a;
        bus.jtag_wdata = d;
        repeat (4) @(negedge clk);
        bus.jtag_wram_enable = 1'b1;
        first = -1;
        n     = 0;
        got_a = '0;
        got_d = '0;
        for (int k = 1; k <= hi + 8; k++) begin
            @(negedge clk);
            if (bus.mem_we === 1'b1) begin
                n++;
                if (first < 0) begin
                    first = k;
                    got_a = bus.mem_waddr;
                    got_d = bus.mem_wdata;
                end
            end
            if (k == hi) bus.jtag_wram_enable = 1'b0;
        end
    endtask

    task automatic apply_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                               input int hi, input logic [9:0] exp_a);
        int first, n;
        logic [9:0]  ga;
        logic [31:0] gd;
        do_write(a, d, hi, first, n, ga, gd);
        exp_count = exp_count + 16'd1;
        ref_mem[exp_a] = d;
        written_q.push_back(exp_a);
        check({tag, "_nwrites"}, 64'(n), 64'd1);
        check({tag, "_latency"}, 64'(first), 64'd4);
        check({tag, "_addr"}, 64'(ga), 64'(exp_a));
        check({tag, "_data"}, 64'(gd), 64'(d));
        check({tag, "_wr_count"}, 64'(bus.wr_count), 64'(exp_count));
    endtask

    task automatic do_read(input string tag, input logic [9:0] a);
        bus.jtag_raddr = {22'h0, a};
        repeat (5) @(negedge clk);
        check({tag, "_rdata"}, 64'(bus.jtag_rdata), 64'(ref_mem[a]));
    endtask

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        int          hi;
        logic [9:0]  exp_a;
    } vec_t;
    vec_t vecs [5];

`ifdef JTAG_MEM_AUTOINC_EN
    localparam logic [31:0] FLAG_MASK = 32'hFFFF_FFFE;
`else
    localparam logic [31:0] FLAG_MASK = 32'hFFFF_FFFF;
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, n, we0;
        logic [9:0]  ga;
        logic [31:0] gd;

        vecs[0] = '{32'h0000_0005, 32'hDEAD_BEEF, 6, 10'h005};
        vecs[1] = '{32'hFFFF_FC00, 32'h0000_0000, 2, 10'h000};
        vecs[2] = '{32'h0000_03FF, 32'hFFFF_FFFF, 2, 10'h3FF};
        vecs[3] = '{32'h1234_5678, 32'hA5A5_A5A5, 3, 10'h278};
        vecs[4] = '{32'h0000_0200, 32'h0000_0001, 4, 10'h200};

        for (int i = 0; i < 1024; i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end
        exp_count            = '0;
        reset                = 1'b1;
        bus.jtag_wram_enable = 1'b1;
        bus.jtag_wdata       = '0;
        bus.jtag_waddr       = '0;
        bus.jtag_raddr       = '0;
        bus.jtag_flags       = '0;
        bus.mem_rdata        = '0;

        // Reset values with the strobe held high
        repeat (3) @(negedge clk);
        check("rst_mem_we", 64'(bus.mem_we), 64'd0);
        check("rst_mem_waddr", 64'(bus.mem_waddr), 64'd0);
        check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst_mem_raddr", 64'(bus.mem_raddr), 64'd0);
        check("rst_jtag_rdata", 64'(bus.jtag_rdata), 64'd0);
        check("rst_wr_count", 64'(bus.wr_count), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd1);

        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("held_strobe_no_we", 64'(we_total), 64'd0);
        check("held_strobe_count", 64'(bus.wr_count), 64'd0);
        check("held_strobe_busy", 64'(bus.busy), 64'd1);
        bus.jtag_wram_enable = 1'b0;
        @(negedge clk);
        check("busy_still_high", 64'(bus.busy), 64'd1);
        repeat (2) @(negedge clk);
        check("busy_fell", 64'(bus.busy), 64'd0);

        // Vector table: write, then read back
        for (int i = 0; i < 5; i++) begin
            apply_write($sformatf("vec%0d", i), vecs[i].waddr, vecs[i].wdata, vecs[i].hi, vecs[i].exp_a);
            do_read($sformatf("vec%0d", i), vecs[i].exp_a);
            check($sformatf("vec%0d_tbl", i), 64'(bus.jtag_rdata), 64'(vecs[i].wdata));
        end

        // Single-cycle strobe: at most one write, count consistent
        we0 = we_total;
        do_write(32'h0000_0123, 32'h1357_9BDF, 1, first, n, ga, gd);
        check("pulse_at_most_one", 64'(n <= 1), 64'd1);
        check("pulse_we_total", 64'(we_total - we0), 64'(n));
        check("pulse_wr_count", 64'(bus.wr_count), 64'(exp_count + 16'(n)));
        exp_count = exp_count + 16'(n);
        if (n == 1) ref_mem[10'h123] = 32'h1357_9BDF;

        // Reset asserted while in SETTLE drops the write
        bus.jtag_waddr = 32'h0000_0077;
        bus.jtag_wdata = 32'hCAFE_0001;
        repeat (4) @(negedge clk);
        bus.jtag_wram_enable = 1'b1;
        repeat (3) @(negedge clk);
        we0   = we_total;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        bus.jtag_wram_enable = 1'b0;
        repeat (6) @(negedge clk);
        exp_count = '0;
        check("settle_rst_no_we", 64'(we_total - we0), 64'd0);
        check("settle_rst_count", 64'(bus.wr_count), 64'd0);
        check("settle_rst_busy", 64'(bus.busy), 64'd0);
        apply_write("after_rst", 32'h0000_0077, 32'hCAFE_0002, 3, 10'h077);
        do_read("after_rst", 10'h077);

`ifdef JTAG_MEM_AUTOINC_EN
        bus.jtag_flags = 32'h1;
        for (int i = 0; i < 3; i++)
            apply_write($sformatf("autoinc%0d", i), 32'h0000_03FE, 32'(i + 1), 3, 10'((32'h3FE + i) % 1024));
        for (int i = 0; i < 3; i++)
            do_read($sformatf("autoinc%0d", i), 10'((32'h3FE + i) % 1024));
        bus.jtag_flags = 32'h0;
`else
        bus.jtag_flags = 32'h1;
        apply_write("flags_ign0", 32'h0000_03FE, 32'h1, 3, 10'h3FE);
        apply_write("flags_ign1", 32'h0000_03FE, 32'h2, 3, 10'h3FE);
        do_read("flags_ign", 10'h3FE);
        bus.jtag_flags = 32'h0;
`endif

        // Randomized writes, then random read-back of written addresses
        for (int i = 0; i < 24; i++) begin
            logic [31:0] ra, rd;
            ra = $urandom;
            rd = $urandom;
            bus.jtag_flags = $urandom & FLAG_MASK;
            apply_write($sformatf("rnd%0d", i), ra, rd, int'($urandom_range(2, 6)), ra[9:0]);
        end
        bus.jtag_flags = 32'h0;
        for (int i = 0; i < 10; i++) begin
            int idx;
            idx = int'($urandom_range(0, written_q.size() - 1));
            do_read($sformatf("rnd_rd%0d", i), written_q[idx]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
